data_normal_pipe: RTL and testbench

DATA_NORMAL_PIPE -- requirements
Module: data_normal_pipe

---
 rtl/data_normal_pkg.sv | 22 ++
 rtl/data_normal_pipe_lane.sv | 66 ++++++
 rtl/data_normal_pipe.sv | 121 ++++++++++++
 tb/tb_data_normal_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_normal_pkg.sv
// Shared types and width helpers for the data normalisation pipeline.
package data_normal_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_SCALE  = 2'd1,
    MODE_BYPASS = 2'd2
  } mode_e;

  localparam int SAT_CNT_W = 16;

  function automatic int prod_width(input int din_w, input int fac_w);
    return din_w + fac_w;
  endfunction

  // Right shift that maps the full product back onto the output width.
  function automatic int rnd_shift(input int din_w, input int fac_w,
                                   input int dout_w, input int shift);
    return din_w + fac_w - dout_w - shift;
  endfunction

endpackage

// File: rtl/data_normal_pipe_lane.sv
// One channel: S1 product/threshold register, then combinational round and saturate.
module norm_lane
  import data_normal_pkg::*;
#(
  parameter int DIN_WIDTH    = 11,
  parameter int FACTOR_WIDTH = 11,
  parameter int DOUT_WIDTH   = 11,
  parameter int SHIFT        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_i,
  input  logic [DIN_WIDTH-1:0]    d_i,
  input  logic [FACTOR_WIDTH-1:0] f_i,
  input  logic [1:0]              mode_i,
  output logic [DOUT_WIDTH-1:0]   res_o,
  output logic                    sat_o
);

  localparam int N = prod_width(DIN_WIDTH, FACTOR_WIDTH);
  localparam int R = rnd_shift(DIN_WIDTH, FACTOR_WIDTH, DOUT_WIDTH, SHIFT);
  localparam logic [N:0] OUT_MAX = (N+1)'({DOUT_WIDTH{1'b1}});
  localparam logic [N:0] RND = (R > 0) ? (N+1)'(1) << (R > 0 ? R - 1 : 0) : '0;

  logic [N-1:0]         d_ext, f_ext;
  logic [N-1:0]         p_q;
  logic [DIN_WIDTH-1:0] d_q;
  logic                 below_q;
  logic [N:0]           sum, scaled, val;

  assign d_ext = N'(d_i);
  assign f_ext = N'(f_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      d_q     <= '0;
      below_q <= 1'b0;
    end else if (ld_i) begin
      p_q     <= d_ext * f_ext;
      d_q     <= d_i;
      below_q <= d_ext < f_ext;
    end
  end

  assign sum    = {1'b0, p_q} + RND;
  assign scaled = sum >> R;

  always_comb begin
    res_o = '0;
    sat_o = 1'b0;
    val   = scaled;
    if (mode_i == MODE_BYPASS) val = (N+1)'(d_q);
    // Anything other than scale/bypass behaves as threshold mode.
    if (mode_i != MODE_SCALE && mode_i != MODE_BYPASS && below_q) begin
      res_o = '0;
      sat_o = 1'b0;
    end else if (val > OUT_MAX) begin
      res_o = '1;
      sat_o = 1'b1;
    end else begin
      res_o = val[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/data_normal_pipe.sv
// Two-stage valid/ready normalisation pipe: per-channel multiply, then round/saturate.
module data_normal_pipe
  import data_normal_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIN_WIDTH    = 11,
  parameter int FACTOR_WIDTH = 11,
  parameter int DOUT_WIDTH   = 11,
  parameter int SHIFT        = 0,
  parameter int FACTOR_RST   = 2**(FACTOR_WIDTH-1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [NUM_CH*DIN_WIDTH-1:0]                 in_data,
  input  logic                                        in_last,
  input  logic [1:0]                                  mode,
  input  logic                                        factor_wr,
  input  logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0]    factor_ch,
  input  logic [FACTOR_WIDTH-1:0]                     factor_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUM_CH*DOUT_WIDTH-1:0]                out_data,
  output logic                                        out_last,
  output logic [SAT_CNT_W-1:0]                        sat_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [FACTOR_WIDTH-1:0] F_RST = FACTOR_WIDTH'(FACTOR_RST);

  logic [FACTOR_WIDTH-1:0]          fac_q [NUM_CH];
  logic                             v1_q, v1_d, v2_q, v2_d;
  logic                             ld1, ld2;
  logic [1:0]                       mode_q;
  logic                             last1_q;
  logic [NUM_CH*DOUT_WIDTH-1:0]     res;
  logic [NUM_CH-1:0]                sat_vec;
  logic [NUM_CH*DOUT_WIDTH-1:0]     out_data_q;
  logic                             out_last_q;
  logic [SAT_CNT_W-1:0]             sat_cnt_q, sat_cnt_d;
  logic [SAT_CNT_W:0]               sat_sum;

  assign in_ready = !v1_q || !v2_q || out_ready;
  assign ld1      = in_valid && in_ready;
  assign ld2      = v1_q && (!v2_q || out_ready);

  // Out-of-range channel indices simply match no entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) fac_q[c] <= F_RST;
    end else if (factor_wr) begin
      for (int c = 0; c < NUM_CH; c++)
        if (factor_ch == CH_W'(c)) fac_q[c] <= factor_data;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    norm_lane #(
      .DIN_WIDTH    (DIN_WIDTH),
      .FACTOR_WIDTH (FACTOR_WIDTH),
      .DOUT_WIDTH   (DOUT_WIDTH),
      .SHIFT        (SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .ld_i   (ld1),
      .d_i    (in_data[c*DIN_WIDTH +: DIN_WIDTH]),
      .f_i    (fac_q[c]),
      .mode_i (mode_q),
      .res_o  (res[c*DOUT_WIDTH +: DOUT_WIDTH]),
      .sat_o  (sat_vec[c])
    );
  end

  always_comb begin
    v1_d = v1_q;
    if (ld1)      v1_d = 1'b1;
    else if (ld2) v1_d = 1'b0;

    v2_d = v2_q;
    if (ld2)            v2_d = 1'b1;
    else if (out_ready) v2_d = 1'b0;

    sat_sum = {1'b0, sat_cnt_q};
    for (int c = 0; c < NUM_CH; c++) sat_sum = sat_sum + (SAT_CNT_W+1)'(sat_vec[c]);

    sat_cnt_d = sat_cnt_q;
    if (ld2) sat_cnt_d = (sat_sum > (SAT_CNT_W+1)'({SAT_CNT_W{1'b1}})) ? '1 : sat_sum[SAT_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      mode_q     <= '0;
      last1_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      sat_cnt_q <= sat_cnt_d;
      if (ld1) begin
        mode_q  <= mode;
        last1_q <= in_last;
      end
      if (ld2) begin
        out_data_q <= res;
        out_last_q <= last1_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_data_normal_pipe.sv
// Directed bench: default 4-channel instance plus a 5-channel SHIFT=1 instance for saturation.
module tb_data_normal_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, factor_wr, out_valid, out_ready, out_last;
  logic [43:0] in_data, out_data;
  logic [1:0]  mode, factor_ch;
  logic [10:0] factor_data;
  logic [15:0] sat_count;

  logic        s_in_valid, s_in_ready, s_in_last, s_factor_wr, s_out_valid, s_out_last;
  logic [54:0] s_in_data, s_out_data;
  logic [1:0]  s_mode;
  logic [2:0]  s_factor_ch;
  logic [10:0] s_factor_data;
  logic [15:0] s_sat_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_normal_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mode(mode), .factor_wr(factor_wr), .factor_ch(factor_ch),
    .factor_data(factor_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .sat_count(sat_count)
  );

  // Five channels so that index 5 fits the 3-bit channel port yet is out of range.
  data_normal_pipe #(.NUM_CH(5), .SHIFT(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_last(s_in_last), .mode(s_mode), .factor_wr(s_factor_wr), .factor_ch(s_factor_ch),
    .factor_data(s_factor_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_last(s_out_last), .sat_count(s_sat_count)
  );

  function automatic logic [43:0] pack4(input logic [10:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [54:0] rep5(input logic [10:0] a);
    return {a, a, a, a, a};
  endfunction

  function automatic logic [43:0] stream_beat(input int k);
    logic [43:0] v;
    for (int c = 0; c < 4; c++) v[c*11 +: 11] = 11'(k*97 + c*211 + 3);
    return v;
  endfunction

  // Factor 1024 with R=11 reduces to floor((d+1)/2) per channel.
  function automatic logic [43:0] stream_exp(input int k);
    logic [43:0] v;
    for (int c = 0; c < 4; c++) v[c*11 +: 11] = 11'((k*97 + c*211 + 3 + 1) / 2);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic run_beat(input logic [1:0] m, input logic [43:0] d,
                          output logic v, output logic [43:0] q);
    mode = m; in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    v = out_valid; q = out_data;
  endtask

  task automatic run_beat_s(input logic [1:0] m, input logic [54:0] d,
                            output logic v, output logic [54:0] q);
    s_mode = m; s_in_data = d; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick();
    v = s_out_valid; q = s_out_data;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 44'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    mode = 2'd0; in_data = pack4(1024, 1024, 1024, 1024); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== pack4(512, 512, 512, 512)) begin bad++; $display("FAIL lat_data got=%h exp=%h", out_data, pack4(512, 512, 512, 512)); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_modes();
    logic        v;
    logic [43:0] q;
    do_reset();
    run_beat(2'd2, pack4(2047, 0, 1234, 5), v, q);
    total++; if (v !== 1'b1 || q !== pack4(2047, 0, 1234, 5)) begin bad++; $display("FAIL bypass got=%b/%h exp=1/%h", v, q, pack4(2047, 0, 1234, 5)); end
    run_beat(2'd1, pack4(2047, 1, 3, 600), v, q);
    total++; if (q !== pack4(1024, 1, 2, 300)) begin bad++; $display("FAIL scale_mix got=%h exp=%h", q, pack4(1024, 1, 2, 300)); end
    run_beat(2'd0, pack4(2047, 1, 3, 600), v, q);
    total++; if (q !== pack4(1024, 0, 0, 0)) begin bad++; $display("FAIL thresh_mix got=%h exp=%h", q, pack4(1024, 0, 0, 0)); end
    for (int c = 0; c < 4; c++) begin
      factor_wr = 1'b1; factor_ch = 2'(c); factor_data = 11'd200;
      tick();
    end
    factor_wr = 1'b0;
    run_beat(2'd0, pack4(100, 100, 100, 100), v, q);
    total++; if (q !== 44'd0) begin bad++; $display("FAIL thresh_zero got=%h exp=0", q); end
    run_beat(2'd3, pack4(100, 100, 100, 100), v, q);
    total++; if (q !== 44'd0) begin bad++; $display("FAIL mode3_zero got=%h exp=0", q); end
    run_beat(2'd1, pack4(100, 100, 100, 100), v, q);
    total++; if (q !== pack4(10, 10, 10, 10)) begin bad++; $display("FAIL scale_round got=%h exp=%h", q, pack4(10, 10, 10, 10)); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL modes_sat got=%0d exp=0", sat_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 2'd1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (cyc < 4); in_data = stream_beat(cyc); in_last = 1'b0;
      #1;
      if (cyc < 4) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
      end
      tick();
      if (cyc >= 1 && cyc <= 4) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== stream_exp(cyc - 1)) begin
          bad++; $display("FAIL b2b_out cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data, stream_exp(cyc - 1));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [3:0]  pat = 4'b1001;
    int          sent = 0, rcv = 0;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [43:0] prev_data = '0;
    do_reset();
    mode = 2'd1;
    for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_data   = stream_beat(sent);
      in_last   = (sent % 3 == 2);
      #1;
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== stream_exp(rcv) || out_last !== (rcv % 3 == 2)) begin
          bad++; $display("FAIL stall_order beat=%0d got=%h/%b exp=%h/%b", rcv, out_data, out_last, stream_exp(rcv), (rcv % 3 == 2));
        end
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    total++; if (rcv != 8) begin bad++; $display("FAIL stall_count got=%0d exp=8", rcv); end
  endtask

  task automatic test_factor_write();
    do_reset();
    mode = 2'd1; in_data = pack4(1024, 1024, 1024, 1024); in_valid = 1'b1;
    factor_wr = 1'b1; factor_ch = 2'd2; factor_data = 11'd512;
    tick();
    factor_wr = 1'b0;
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== pack4(512, 512, 512, 512)) begin bad++; $display("FAIL fwr_old got=%h exp=%h", out_data, pack4(512, 512, 512, 512)); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== pack4(512, 512, 256, 512)) begin bad++; $display("FAIL fwr_new got=%b/%h exp=1/%h", out_valid, out_data, pack4(512, 512, 256, 512)); end
  endtask

  task automatic test_sat();
    logic        v;
    logic [54:0] q;
    do_reset();
    s_factor_wr = 1'b1; s_factor_ch = 3'd5; s_factor_data = 11'd512;
    tick();
    s_factor_wr = 1'b0;
    run_beat_s(2'd1, rep5(1024), v, q);
    total++; if (v !== 1'b1 || q !== rep5(1024)) begin bad++; $display("FAIL ch5_ignored got=%b/%h exp=1/%h", v, q, rep5(1024)); end
    for (int c = 0; c < 5; c++) begin
      s_factor_wr = 1'b1; s_factor_ch = 3'(c); s_factor_data = 11'd2047;
      tick();
    end
    s_factor_wr = 1'b0;
    s_mode = 2'd1; s_in_data = rep5(2047); s_in_valid = 1'b1;
    tick();
    tick();
    s_in_valid = 1'b0;
    total++; if (s_out_data !== rep5(2047)) begin bad++; $display("FAIL sat_data got=%h exp=%h", s_out_data, rep5(2047)); end
    total++; if (s_sat_count !== 16'd5) begin bad++; $display("FAIL sat_cnt1 got=%0d exp=5", s_sat_count); end
    tick();
    total++; if (s_sat_count !== 16'd10) begin bad++; $display("FAIL sat_cnt2 got=%0d exp=10", s_sat_count); end
  endtask

  task automatic test_reset_midstream();
    logic        v;
    logic [43:0] q;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      s_factor_wr = 1'b1; s_factor_ch = 3'(c); s_factor_data = 11'd2047;
      factor_wr = (c == 0); factor_ch = 2'd0; factor_data = 11'd512;
      tick();
    end
    s_factor_wr = 1'b0; factor_wr = 1'b0;
    mode = 2'd1; in_data = pack4(1024, 1024, 1024, 1024);
    s_mode = 2'd1; s_in_data = rep5(2047);
    in_valid = 1'b1; s_in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; s_in_valid = 1'b0;
    total++; if (s_sat_count !== 16'd5) begin bad++; $display("FAIL mid_pre_sat got=%0d exp=5", s_sat_count); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || s_out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b/%b exp=0/0", out_valid, s_out_valid); end
    total++; if (s_sat_count !== 16'd0 || out_data !== 44'd0) begin bad++; $display("FAIL mid_clear got=%0d/%h exp=0/0", s_sat_count, out_data); end
    #1 rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_release got=%b/%b exp=1/0", in_ready, out_valid); end
    run_beat(2'd1, pack4(1024, 1024, 1024, 1024), v, q);
    total++; if (q !== pack4(512, 512, 512, 512)) begin bad++; $display("FAIL mid_factor got=%h exp=%h", q, pack4(512, 512, 512, 512)); end
    total++; if (s_sat_count !== 16'd0 || s_out_valid !== 1'b0) begin bad++; $display("FAIL mid_s_idle got=%0d/%b exp=0/0", s_sat_count, s_out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = '0;
    factor_wr = 1'b0; factor_ch = '0; factor_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_mode = '0;
    s_factor_wr = 1'b0; s_factor_ch = '0; s_factor_data = '0;
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_stall();
    test_factor_write();
    test_sat();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
